// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// FSM states, ALU operations and the decoded instruction classes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_NOP  = 4'd0,
    C_ADDU = 4'd1,
    C_SUBU = 4'd2,
    C_ORI  = 4'd3,
    C_LUI  = 4'd4,
    C_LW   = 4'd5,
    C_LB   = 4'd6,
    C_SW   = 4'd7,
    C_SB   = 4'd8,
    C_BEQ  = 4'd9,
    C_J    = 4'd10
  } iclass_t;

  function automatic logic is_load(input iclass_t c);
    return (c == C_LW) || (c == C_LB);
  endfunction

  function automatic logic is_store(input iclass_t c);
    return (c == C_SW) || (c == C_SB);
  endfunction

  function automatic logic is_byte(input iclass_t c);
    return (c == C_LB) || (c == C_SB);
  endfunction

  function automatic logic is_rtype(input iclass_t c);
    return (c == C_ADDU) || (c == C_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the IR word to one class.
// Anything not explicitly recognised is a nop.
module mc_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [3:0]  o_class
);

  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];

  always_comb begin
    o_class = C_NOP;
    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FN_ADDU)      o_class = C_ADDU;
        else if (w_funct == FN_SUBU) o_class = C_SUBU;
      end
      OP_ORI:  o_class = C_ORI;
      OP_LUI:  o_class = C_LUI;
      OP_LW:   o_class = C_LW;
      OP_LB:   o_class = C_LB;
      OP_SW:   o_class = C_SW;
      OP_SB:   o_class = C_SB;
      OP_BEQ:  o_class = C_BEQ;
      OP_J:    o_class = C_J;
      default: o_class = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM. Only the state is registered; every control
// output is a combinational function of state, instr, zero and mem_ready.
module mc_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic        MemtoReg,
  output logic        Extop,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        ByteOp,
  output logic [2:0]  ALUOp,
  output logic [1:0]  NPCSel,
  output logic        instr_done,
  output logic [2:0]  state
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_class_raw;
  iclass_t    w_class;

  mc_decode u_decode (
    .i_instr (instr),
    .o_class (w_class_raw)
  );

  assign w_class = iclass_t'(w_class_raw);
  assign state   = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RegWr      = 1'b0;
    MemWr      = 1'b0;
    MemtoReg   = 1'b0;
    Extop      = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    ByteOp     = 1'b0;
    ALUOp      = ALU_ADD;
    NPCSel     = NPC_PC4;
    instr_done = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          IRWr   = 1'b1;
          PCWr   = 1'b1;
          NPCSel = NPC_PC4;
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_class)
          C_J: begin
            PCWr       = 1'b1;
            NPCSel     = NPC_JMP;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          C_NOP: begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        ByteOp = is_byte(w_class);
        case (w_class)
          C_ADDU: begin
            ALUOp  = ALU_ADD;
            w_next = S_WB;
          end
          C_SUBU: begin
            ALUOp  = ALU_SUB;
            w_next = S_WB;
          end
          C_ORI: begin
            ALUOp  = ALU_OR;
            ALUSrc = 1'b1;
            w_next = S_WB;
          end
          C_LUI: begin
            ALUOp  = ALU_LUI;
            ALUSrc = 1'b1;
            w_next = S_WB;
          end
          C_LW, C_LB, C_SW, C_SB: begin
            ALUOp  = ALU_ADD;
            ALUSrc = 1'b1;
            Extop  = 1'b1;
            w_next = S_MEM;
          end
          C_BEQ: begin
            ALUOp      = ALU_SUB;
            PCWr       = zero;
            NPCSel     = NPC_BR;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        ByteOp = is_byte(w_class);
        if (mem_ready) begin
          if (is_store(w_class)) begin
            MemWr      = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end

      S_WB: begin
        ByteOp     = is_byte(w_class);
        RegWr      = 1'b1;
        MemtoReg   = is_load(w_class);
        RegDst     = is_rtype(w_class);
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      default: w_next = S_FETCH;
    endcase

    // Reset must silence outputs even in FETCH, where mem_ready alone would strobe IR/PC.
    if (!reset) begin
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RegWr      = 1'b0;
      MemWr      = 1'b0;
      MemtoReg   = 1'b0;
      Extop      = 1'b0;
      RegDst     = 1'b0;
      ALUSrc     = 1'b0;
      ByteOp     = 1'b0;
      ALUOp      = ALU_ADD;
      NPCSel     = NPC_PC4;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle and
// compares the state and the packed control word against hand-derived values.
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        PCWr, IRWr, RegWr, MemWr, MemtoReg, Extop, RegDst, ALUSrc, ByteOp;
  logic [2:0]  ALUOp;
  logic [1:0]  NPCSel;
  logic        instr_done;
  logic [2:0]  state;
  logic [14:0] w_ctl;

  int n_checks = 0;
  int n_pass   = 0;

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWr       (PCWr),
    .IRWr       (IRWr),
    .RegWr      (RegWr),
    .MemWr      (MemWr),
    .MemtoReg   (MemtoReg),
    .Extop      (Extop),
    .RegDst     (RegDst),
    .ALUSrc     (ALUSrc),
    .ByteOp     (ByteOp),
    .ALUOp      (ALUOp),
    .NPCSel     (NPCSel),
    .instr_done (instr_done),
    .state      (state)
  );

  assign w_ctl = {PCWr, IRWr, RegWr, MemWr, MemtoReg, Extop, RegDst, ALUSrc,
                  ByteOp, ALUOp, NPCSel, instr_done};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packs an expected control word in the same field order as w_ctl
  function automatic logic [14:0] mk(input logic pc, input logic ir, input logic rw,
                                     input logic mw, input logic m2r, input logic ext,
                                     input logic rd, input logic src, input logic bo,
                                     input logic [2:0] op, input logic [1:0] npc,
                                     input logic done);
    return {pc, ir, rw, mw, m2r, ext, rd, src, bo, op, npc, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // called at a negedge: drive inputs, check mid-low-phase, advance one clock
  task automatic cyc(input string tag, input logic mr, input logic z,
                     input logic [2:0] es, input logic [14:0] ec);
    mem_ready = mr;
    zero      = z;
    #1;
    check({tag, "_state"}, {29'd0, state}, {29'd0, es});
    check({tag, "_ctl"},   {17'd0, w_ctl}, {17'd0, ec});
    @(negedge clk);
  endtask

  logic [14:0] k_fetch;
  logic [14:0] k_idle;
  logic [14:0] k_mem_ex;

  initial begin
    k_fetch  = mk(1,1,0,0,0,0,0,0,0,3'b000,2'b00,0);
    k_idle   = 15'd0;
    k_mem_ex = mk(0,0,0,0,0,1,0,1,0,3'b000,2'b00,0);

    reset     = 1'b0;
    instr     = 32'h0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_ctl",   {17'd0, w_ctl}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_ctl_clk", {17'd0, w_ctl}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // FETCH holds without mem_ready, then addu
    instr = 32'h00221821;
    cyc("fetch_hold0", 0, 0, 3'd0, k_idle);
    cyc("fetch_hold1", 0, 0, 3'd0, k_idle);
    cyc("addu_f",  1, 0, 3'd0, k_fetch);
    cyc("addu_d",  1, 0, 3'd1, k_idle);
    cyc("addu_e",  1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,0,3'b000,2'b00,0));
    cyc("addu_wb", 1, 0, 3'd4, mk(0,0,1,0,0,0,1,0,0,3'b000,2'b00,1));

    instr = 32'h00221823;
    cyc("subu_f",  1, 0, 3'd0, k_fetch);
    cyc("subu_d",  1, 0, 3'd1, k_idle);
    cyc("subu_e",  1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,0,3'b001,2'b00,0));
    cyc("subu_wb", 1, 0, 3'd4, mk(0,0,1,0,0,0,1,0,0,3'b000,2'b00,1));

    instr = 32'h8C040008;
    cyc("lw_f",   1, 0, 3'd0, k_fetch);
    cyc("lw_d",   1, 0, 3'd1, k_idle);
    cyc("lw_e",   1, 0, 3'd2, k_mem_ex);
    cyc("lw_m",   1, 0, 3'd3, k_idle);
    cyc("lw_wb",  1, 0, 3'd4, mk(0,0,1,0,1,0,0,0,0,3'b000,2'b00,1));

    instr = 32'h10220001;
    cyc("beq1_f", 1, 1, 3'd0, k_fetch);
    cyc("beq1_d", 1, 1, 3'd1, k_idle);
    cyc("beq1_e", 1, 1, 3'd2, mk(1,0,0,0,0,0,0,0,0,3'b001,2'b01,1));
    cyc("beq0_f", 1, 0, 3'd0, k_fetch);
    cyc("beq0_d", 1, 0, 3'd1, k_idle);
    cyc("beq0_e", 1, 0, 3'd2, mk(0,0,0,0,0,0,0,0,0,3'b001,2'b01,1));

    instr = 32'hAC050004;
    cyc("sw_f",   1, 0, 3'd0, k_fetch);
    cyc("sw_d",   1, 0, 3'd1, k_idle);
    cyc("sw_e",   1, 0, 3'd2, k_mem_ex);
    cyc("sw_mw0", 0, 0, 3'd3, k_idle);
    cyc("sw_mw1", 0, 0, 3'd3, k_idle);
    cyc("sw_mw2", 0, 0, 3'd3, k_idle);
    cyc("sw_m",   1, 0, 3'd3, mk(0,0,0,1,0,0,0,0,0,3'b000,2'b00,1));

    instr = 32'h08000004;
    cyc("j_f",    1, 0, 3'd0, k_fetch);
    cyc("j_d",    1, 0, 3'd1, mk(1,0,0,0,0,0,0,0,0,3'b000,2'b10,1));

    instr = 32'hFFFFFFFF;
    cyc("nop_f",  1, 0, 3'd0, k_fetch);
    cyc("nop_d",  1, 0, 3'd1, mk(0,0,0,0,0,0,0,0,0,3'b000,2'b00,1));

    instr = 32'h3402FFFF;
    cyc("ori_f",  1, 0, 3'd0, k_fetch);
    cyc("ori_d",  1, 0, 3'd1, k_idle);
    cyc("ori_e",  1, 0, 3'd2, mk(0,0,0,0,0,0,0,1,0,3'b010,2'b00,0));
    cyc("ori_wb", 1, 0, 3'd4, mk(0,0,1,0,0,0,0,0,0,3'b000,2'b00,1));

    instr = 32'h3C021234;
    cyc("lui_f",  1, 0, 3'd0, k_fetch);
    cyc("lui_d",  1, 0, 3'd1, k_idle);
    cyc("lui_e",  1, 0, 3'd2, mk(0,0,0,0,0,0,0,1,0,3'b011,2'b00,0));
    cyc("lui_wb", 1, 0, 3'd4, mk(0,0,1,0,0,0,0,0,0,3'b000,2'b00,1));

    instr = 32'h80040003;
    cyc("lb_f",   1, 0, 3'd0, k_fetch);
    cyc("lb_d",   1, 0, 3'd1, k_idle);
    cyc("lb_e",   1, 0, 3'd2, mk(0,0,0,0,0,1,0,1,1,3'b000,2'b00,0));
    cyc("lb_m",   1, 0, 3'd3, mk(0,0,0,0,0,0,0,0,1,3'b000,2'b00,0));
    cyc("lb_wb",  1, 0, 3'd4, mk(0,0,1,0,1,0,0,0,1,3'b000,2'b00,1));

    // sb interrupted by reset while waiting in MEM
    instr = 32'hA0050004;
    cyc("sb_f",   1, 0, 3'd0, k_fetch);
    cyc("sb_d",   1, 0, 3'd1, k_idle);
    cyc("sb_e",   1, 0, 3'd2, mk(0,0,0,0,0,1,0,1,1,3'b000,2'b00,0));
    cyc("sb_mw",  0, 0, 3'd3, mk(0,0,0,0,0,0,0,0,1,3'b000,2'b00,0));
    mem_ready = 1'b1;
    reset     = 1'b0;
    #1;
    check("sbrst_state", {29'd0, state}, 32'd0);
    check("sbrst_ctl",   {17'd0, w_ctl}, 32'd0);
    check("sbrst_memwr", {31'd0, MemWr}, 32'd0);
    @(posedge clk);
    #1;
    check("sbrst_clk_state", {29'd0, state}, 32'd0);
    check("sbrst_clk_memwr", {31'd0, MemWr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    instr = 32'h00221821;
    cyc("post_f",  1, 0, 3'd0, k_fetch);
    cyc("post_d",  1, 0, 3'd1, k_idle);
    cyc("post_e",  1, 0, 3'd2, k_idle);
    cyc("post_wb", 1, 0, 3'd4, mk(0,0,1,0,0,0,1,0,0,3'b000,2'b00,1));
    cyc("post_f2", 1, 0, 3'd0, k_fetch);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 = reset.
REQ-003 SHALL have port instr, input, 32 bits: IR contents, valid from DECODE onward.
REQ-004 SHALL have port zero, input, 1 bit: ALU equality flag, sampled in EXEC.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory handshake, completes FETCH/MEM access.
REQ-006 SHALL have outputs PCWr, IRWr, RegWr, MemWr, 1 bit each: write strobes for PC, IR, RF, DM.
REQ-007 SHALL have outputs MemtoReg, Extop, RegDst, ALUSrc, ByteOp, 1 bit each: datapath mux selects (ByteOp=1 for lb/sb).
REQ-008 SHALL have output ALUOp, 3 bits: 000 add, 001 sub, 010 or, 011 lui (imm<<16).
REQ-009 SHALL have output NPCSel, 2 bits: 00 PC+4, 01 branch, 10 jump.
REQ-010 SHALL have output instr_done, 1 bit: pulse in the last cycle of each instruction.
REQ-011 SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-012 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-013 SHALL decode addu (op 0, funct 100001), subu (op 0, funct 100011), ori 001101, lui 001111, lw 100011, lb 100000, sw 101011, sb 101000, beq 000100, j 000010; every other encoding is a nop.
REQ-014 SHALL hold FETCH while mem_ready=0; with mem_ready=1, assert IRWr=1, PCWr=1, NPCSel=00 for that cycle and go to DECODE.
REQ-015 SHALL, in DECODE, go to EXEC for every decoded instruction except j and nop.
REQ-016 SHALL, for j in DECODE, assert PCWr=1, NPCSel=10, instr_done=1 and go to FETCH.
REQ-017 SHALL, for nop in DECODE, assert instr_done=1 and go to FETCH with no write strobes.
REQ-018 SHALL, in EXEC, drive ALUOp/ALUSrc/Extop per instruction: R-type ALUSrc=0; ori ALUSrc=1, Extop=0; lw/lb/sw/sb ALUSrc=1, Extop=1, ALUOp=000; beq ALUSrc=0, ALUOp=001.
REQ-019 SHALL, for beq in EXEC, assert PCWr=zero, NPCSel=01, instr_done=1 and go to FETCH.
REQ-020 SHALL go from EXEC to MEM for loads/stores and to WB for R-type, ori and lui.
REQ-021 SHALL hold MEM while mem_ready=0; stores SHALL assert MemWr=1 only in the mem_ready=1 cycle, with instr_done=1, then go to FETCH.
REQ-022 SHALL, for loads, go from MEM (mem_ready=1) to WB.
REQ-023 SHALL, in WB, assert RegWr=1 and instr_done=1 for exactly one cycle, then go to FETCH.
REQ-024 SHALL, in WB, set MemtoReg=1 for loads (else 0) and RegDst=1 for R-type (else 0).
REQ-025 SHALL hold ByteOp=1 for lb/sb in EXEC, MEM and WB.
REQ-026 SHALL give cycle counts with mem_ready tied high: j/nop 2; beq 3; R/ori/lui/sw/sb 4; lw/lb 5.
REQ-027 SHALL never assert two of PCWr/IRWr, RegWr or MemWr in the same cycle, except PCWr with IRWr in FETCH.
REQ-028 SHALL drive all outputs combinationally from state, instr, zero and mem_ready, and SHALL register only the state.

Reset
REQ-029 SHALL, on reset=0, enter FETCH immediately, regardless of clk.
REQ-030 SHALL, during reset, force all strobes and instr_done to 0, all selects to 0, ALUOp=000 and NPCSel=00.
REQ-031 SHALL, if reset occurs mid-MEM or mid-WB, suppress the pending write.
REQ-032 SHALL, once reset is released, start with FETCH in the first clk edge.

Structure
REQ-033 SHALL place opcode, funct, state and ALUOp encodings in shared package mips_pkg.
REQ-034 SHALL use one sub-module, mc_decode: combinational mapping of instr to instruction class.

Verification
REQ-035 SHALL cover: instr=0x00221821 (addu), mem_ready=1 -> states 0,1,2,4; RegWr=1, RegDst=1 in WB only; instr_done=1 at cycle 4.
REQ-036 SHALL cover: instr=0x8C040008 (lw) -> 5 cycles; MemtoReg=1, RegWr=1 in WB; ALUSrc=1, Extop=1 in EXEC.
REQ-037 SHALL cover: instr=0x10220001 (beq), zero=1 then zero=0 -> PCWr=1, NPCSel=01 in EXEC only when zero=1; 3 cycles each.
REQ-038 SHALL cover: instr=0xAC050004 (sw), mem_ready low 3 cycles in MEM -> MEM held 3 cycles; MemWr=1 for one cycle at mem_ready=1.
REQ-039 SHALL cover: instr=0x08000004 (j) -> PCWr=1, NPCSel=10 in DECODE; next state FETCH.
REQ-040 SHALL cover: reset=0 asserted mid-MEM of sb -> state=0 immediately, MemWr never 1.
